// File: rtl/lottery_pkg.sv
// Shared types and defaults for the lottery ticket checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lottery_pkg;

  localparam int NUM_PICKS   = 4;
  localparam int DEF_MAX_NUM = 31;
  localparam int DEF_MIN_WIN = 3;

  typedef logic [4:0] num_t;
  typedef logic [NUM_PICKS-1:0][4:0] num_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    REPORT,
    ERROR
  } state_t;

endpackage

// File: rtl/pick_compare.sv
// Compares one pick against four reference numbers; hit if any unmasked entry is equal.
// Latency: purely combinational.
// Backpressure: none.
//   pick : number under test
//   vals : four reference numbers (entry 0 in the low slice)
//   mask : entry i takes part in the compare only when mask[i] is set
//   hit  : at least one enabled entry equals pick
module pick_compare
  import lottery_pkg::*;
(
  input  num_t                 pick,
  input  num_vec_t             vals,
  input  logic [NUM_PICKS-1:0] mask,
  output logic                 hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_PICKS; i++) begin
      if (mask[i] && (pick == vals[i])) hit = 1'b1;
    end
  end

endmodule

// File: rtl/lottery_controller.sv
// Checks one four-pick lottery ticket against latched winning numbers and reports matches.
// Latency: READY 1 cycle after SYSRDY; result/DONE 5 cycles after the 4th accepted pick.
// Backpressure: picks accepted only while READY; NUM_VLD ignored elsewhere, CLR always wins.
//   CLK, RST          : clock, async active-high reset
//   W1..W4, SYSRDY    : winning numbers and their validity flag
//   NUM, NUM_VLD      : serial player picks
//   CLR               : abort / acknowledge, returns to IDLE
//   READY/BUSY/ERR    : decoded from state (ENTRY/CHECK/ERROR)
//   DONE              : registered one-cycle pulse on REPORT entry
//   MATCHES, WIN      : result, nonzero only in REPORT
module lottery_controller
  import lottery_pkg::*;
#(
  parameter int MAX_NUM = DEF_MAX_NUM,
  parameter int MIN_WIN = DEF_MIN_WIN
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] W1,
  input  logic [4:0] W2,
  input  logic [4:0] W3,
  input  logic [4:0] W4,
  input  logic       SYSRDY,
  input  logic [4:0] NUM,
  input  logic       NUM_VLD,
  input  logic       CLR,
  output logic       READY,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] MATCHES,
  output logic       WIN,
  output logic       ERR
);

  // 6-bit range check so MAX_NUM = 31 still yields a real comparison.
  localparam logic [5:0] MAX_V = 6'(MAX_NUM);
  localparam logic [2:0] WIN_V = 3'(MIN_WIN);

  state_t   state_q, state_d;
  num_vec_t wl_q;          // winning numbers latched on IDLE exit
  num_vec_t picks_q;       // accepted picks, index = acceptance order
  logic [1:0] pcnt_q;      // number of picks accepted so far (wraps on 4th)
  logic [1:0] idx_q;       // pick under comparison in CHECK
  logic [2:0] mcnt_q;      // match counter, max 4
  logic       done_q;

  logic latch_w, store_pick, step_chk;
  logic num_ok, pick_legal, hit;

  num_t                 cmp_pick;
  num_vec_t             cmp_vals;
  logic [NUM_PICKS-1:0] cmp_mask;
  logic [NUM_PICKS-1:0] dup_mask;

  // Only picks already accepted count for the duplicate check.
  always_comb begin
    dup_mask = '0;
    for (int i = 0; i < NUM_PICKS; i++) begin
      dup_mask[i] = (2'(i) < pcnt_q);
    end
  end

  // One comparator shared: stored pick vs winners in CHECK,
  // incoming pick vs stored picks otherwise (duplicate detection).
  always_comb begin
    if (state_q == CHECK) begin
      cmp_pick = picks_q[idx_q];
      cmp_vals = wl_q;
      cmp_mask = '1;
    end else begin
      cmp_pick = NUM;
      cmp_vals = picks_q;
      cmp_mask = dup_mask;
    end
  end

  pick_compare u_cmp (
    .pick (cmp_pick),
    .vals (cmp_vals),
    .mask (cmp_mask),
    .hit  (hit)
  );

  assign num_ok     = (NUM != 5'd0) && ({1'b0, NUM} <= MAX_V);
  assign pick_legal = num_ok && !hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_w    = 1'b0;
    store_pick = 1'b0;
    step_chk   = 1'b0;
    if (CLR) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (SYSRDY) begin
            state_d = ENTRY;
            latch_w = 1'b1;
          end
        end
        ENTRY: begin
          // A low SYSRDY here means it fell after latching: W no longer trusted.
          if (!SYSRDY) begin
            state_d = ERROR;
          end else if (NUM_VLD) begin
            if (!pick_legal) begin
              state_d = ERROR;
            end else begin
              store_pick = 1'b1;
              if (pcnt_q == 2'd3) state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (!SYSRDY) begin
            state_d = ERROR;
          end else begin
            step_chk = 1'b1;
            if (idx_q == 2'd3) state_d = REPORT;
          end
        end
        REPORT:  state_d = REPORT;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wl_q    <= '0;
      picks_q <= '0;
      pcnt_q  <= '0;
      idx_q   <= '0;
      mcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      if (latch_w) begin
        wl_q    <= {W4, W3, W2, W1};
        picks_q <= '0;
        pcnt_q  <= '0;
      end
      if (store_pick) begin
        picks_q[pcnt_q] <= NUM;
        pcnt_q          <= pcnt_q + 2'd1;
        if (pcnt_q == 2'd3) begin
          idx_q  <= '0;
          mcnt_q <= '0;
        end
      end
      if (step_chk) begin
        idx_q  <= idx_q + 2'd1;
        mcnt_q <= mcnt_q + {2'b00, hit};
      end
      done_q <= (state_q == CHECK) && (state_d == REPORT);
    end
  end

  assign READY   = (state_q == ENTRY);
  assign BUSY    = (state_q == CHECK);
  assign ERR     = (state_q == ERROR);
  assign DONE    = done_q;
  assign MATCHES = (state_q == REPORT) ? mcnt_q : 3'd0;
  assign WIN     = (state_q == REPORT) && (mcnt_q >= WIN_V);

endmodule

// File: tb/tb_lottery_controller.sv
module tb_lottery_controller;

  logic       CLK, RST;
  logic [4:0] W1, W2, W3, W4, NUM;
  logic       SYSRDY, NUM_VLD, CLR;
  logic       READY, BUSY, DONE, WIN, ERR;
  logic [2:0] MATCHES;
  logic       r2, b2, d2, w2, e2;
  logic [2:0] m2;

  int total = 0;
  int bad   = 0;

  // Ticket description consumed by run_ticket
  logic [4:0] tw[4];
  logic [4:0] tp[4];
  int         tn;
  bit         chg_w;

  lottery_controller u_dut (
    .CLK(CLK), .RST(RST), .W1(W1), .W2(W2), .W3(W3), .W4(W4),
    .SYSRDY(SYSRDY), .NUM(NUM), .NUM_VLD(NUM_VLD), .CLR(CLR),
    .READY(READY), .BUSY(BUSY), .DONE(DONE), .MATCHES(MATCHES),
    .WIN(WIN), .ERR(ERR)
  );

  lottery_controller #(.MAX_NUM(20), .MIN_WIN(3)) u_dut20 (
    .CLK(CLK), .RST(RST), .W1(W1), .W2(W2), .W3(W3), .W4(W4),
    .SYSRDY(SYSRDY), .NUM(NUM), .NUM_VLD(NUM_VLD), .CLR(CLR),
    .READY(r2), .BUSY(b2), .DONE(d2), .MATCHES(m2),
    .WIN(w2), .ERR(e2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkm(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ready"}, READY, 1'b0);
    chk1({tag, "_busy"}, BUSY, 1'b0);
    chk1({tag, "_done"}, DONE, 1'b0);
    chkm({tag, "_matches"}, MATCHES, 3'd0);
    chk1({tag, "_win"}, WIN, 1'b0);
    chk1({tag, "_err"}, ERR, 1'b0);
  endtask

  task automatic do_clear();
    CLR = 1'b1;
    NUM_VLD = 1'b0;
    tick();
    CLR = 1'b0;
    chk_idle("clr");
  endtask

  task automatic start_ticket();
    W1 = tw[0]; W2 = tw[1]; W3 = tw[2]; W4 = tw[3];
    SYSRDY = 1'b1;
    tick();
    chk1("start_ready", READY, 1'b1);
  endtask

  // Reference behaviour: a pick is legal when 1..31 and not already accepted;
  // after four legal picks the result is the number of picks that appear
  // among the winning numbers, arriving after four BUSY cycles.
  task automatic run_ticket();
    int  acc[$];
    bit  legal;
    int  m;
    start_ticket();
    for (int k = 0; k < tn; k++) begin
      NUM = tp[k];
      NUM_VLD = 1'b1;
      tick();
      NUM_VLD = 1'b0;
      legal = (tp[k] >= 1) && (tp[k] <= 31);
      foreach (acc[j]) if (acc[j] == int'(tp[k])) legal = 0;
      if (!legal) begin
        chk1("illegal_err", ERR, 1'b1);
        chk1("illegal_ready", READY, 1'b0);
        chkm("illegal_matches", MATCHES, 3'd0);
        tick();
        chk1("err_held", ERR, 1'b1);
        break;
      end
      acc.push_back(int'(tp[k]));
      if (acc.size() < 4) begin
        chk1("entry_ready", READY, 1'b1);
        chk1("entry_err", ERR, 1'b0);
      end else begin
        if (chg_w) begin
          W1 = 5'd1; W2 = 5'd2; W3 = 5'd3; W4 = 5'd4;
        end
        for (int c = 0; c < 4; c++) begin
          chk1("check_busy", BUSY, 1'b1);
          chk1("check_nodone", DONE, 1'b0);
          tick();
        end
        m = 0;
        foreach (acc[i]) for (int j = 0; j < 4; j++) if (acc[i] == int'(tw[j])) m++;
        chk1("report_done", DONE, 1'b1);
        chk1("report_busy", BUSY, 1'b0);
        chkm("report_matches", MATCHES, 3'(m));
        chk1("report_win", WIN, (m >= 3) ? 1'b1 : 1'b0);
        tick();
        chk1("report_done_pulse", DONE, 1'b0);
        chkm("report_hold", MATCHES, 3'(m));
      end
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    tw[0] = 5'(a); tw[1] = 5'(b); tw[2] = 5'(c); tw[3] = 5'(d);
  endtask

  task automatic set_p(input int a, input int b, input int c, input int d, input int n);
    tp[0] = 5'(a); tp[1] = 5'(b); tp[2] = 5'(c); tp[3] = 5'(d);
    tn = n;
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; SYSRDY = 1'b0; NUM_VLD = 1'b0; NUM = '0;
    W1 = '0; W2 = '0; W3 = '0; W4 = '0; chg_w = 0;
    #12;
    chk_idle("reset");
    RST = 1'b0;
    do_clear();

    // All four picks hit
    set_w(5, 12, 19, 27);
    set_p(5, 12, 19, 27, 4);
    run_ticket();
    do_clear();

    // Two hits, result held until CLR
    set_p(1, 12, 30, 27, 4);
    run_ticket();
    tick(); tick();
    chkm("hold_long", MATCHES, 3'd2);
    chk1("hold_win", WIN, 1'b0);
    do_clear();

    // Duplicate pick
    set_p(7, 7, 0, 0, 2);
    run_ticket();
    do_clear();

    // Zero pick
    set_p(0, 0, 0, 0, 1);
    run_ticket();
    do_clear();

    // Pick above 20 on the MAX_NUM=20 instance, legal on the default one
    start_ticket();
    NUM = 5'd25; NUM_VLD = 1'b1;
    tick();
    NUM_VLD = 1'b0;
    chk1("max20_err", e2, 1'b1);
    chk1("max20_ready", r2, 1'b0);
    chk1("max31_ready", READY, 1'b1);
    do_clear();

    // SYSRDY drops after two picks
    set_p(3, 4, 0, 0, 2);
    run_ticket();
    SYSRDY = 1'b0;
    tick();
    chk1("sysrdy_err", ERR, 1'b1);
    chk1("sysrdy_ready", READY, 1'b0);
    do_clear();

    // Winning numbers change during CHECK
    chg_w = 1;
    set_p(5, 12, 19, 27, 4);
    run_ticket();
    chg_w = 0;
    do_clear();

    // Reset in the middle of CHECK
    SYSRDY = 1'b0;
    set_p(5, 6, 7, 8, 3);
    run_ticket();
    NUM = 5'd9; NUM_VLD = 1'b1;
    tick();
    NUM_VLD = 1'b0;
    tick();
    chk1("pre_rst_busy", BUSY, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk_idle("rst_async");
    tick();
    RST = 1'b0;
    SYSRDY = 1'b0;
    chk_idle("rst_hold");
    do_clear();

    // CLR together with NUM_VLD in ENTRY: CLR wins
    set_p(5, 0, 0, 0, 1);
    run_ticket();
    NUM = 5'd9; NUM_VLD = 1'b1; CLR = 1'b1;
    tick();
    NUM_VLD = 1'b0; CLR = 1'b0;
    chk_idle("clr_vs_vld");
    SYSRDY = 1'b0;
    tick();
    set_p(9, 5, 12, 19, 4);
    run_ticket();
    do_clear();

    // Randomized tickets
    for (int t = 0; t < 40; t++) begin
      bit ok;
      do begin
        for (int j = 0; j < 4; j++) tw[j] = 5'($urandom_range(1, 31));
        ok = 1;
        for (int a = 0; a < 4; a++)
          for (int b = a + 1; b < 4; b++)
            if (tw[a] == tw[b]) ok = 0;
      end while (!ok);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) < 2) tp[k] = tw[$urandom_range(0, 3)];
        else                          tp[k] = 5'($urandom_range(0, 31));
      end
      tn = 4;
      run_ticket();
      do_clear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lottery_controller.md
# lottery_controller

Sequences one lottery ticket check against the four hard-wired winning numbers. Gated by the `SYSRDY` flag from the winning-number validator; collects four player picks serially, rejects illegal tickets, then compares picks against latched winning numbers one pick per cycle and reports match count and win flag. Sits between the player-entry front end and the prize/display logic.

## Interface
- `MAX_NUM`, 31, largest legal pick/winning value (1..MAX_NUM legal)
- `MIN_WIN`, 3, match count at or above which `WIN` asserts
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `W1`,`W2`,`W3`,`W4`  in  5 each  winning numbers
- `SYSRDY`  in  1  winning numbers valid (nonzero, distinct)
- `NUM`  in  5  player pick
- `NUM_VLD`  in  1  `NUM` valid this cycle
- `CLR`  in  1  abort / acknowledge result, return to IDLE
- `READY`  out  1  accepting picks
- `BUSY`  out  1  compare in progress
- `DONE`  out  1  one-cycle pulse, result valid
- `MATCHES`  out  3  number of picks equal to any winning number, 0..4
- `WIN`  out  1  `MATCHES >= MIN_WIN`
- `ERR`  out  1  ticket rejected; held until `CLR`

## Operation
- States: IDLE, ENTRY, CHECK, REPORT, ERROR.
- IDLE: outputs low; if `SYSRDY`=1, latch W1..W4 into internal regs, clear pick count, go ENTRY.
- ENTRY: `READY`=1. Each cycle with `NUM_VLD`=1: pick legal if 1<=NUM<=MAX_NUM and not equal to an already accepted pick; legal -> store at index = pick count, count++; illegal -> ERROR. On 4th legal pick go CHECK, index=0, match counter=0.
- `SYSRDY` falling in ENTRY or CHECK -> ERROR (latched W no longer trusted).
- CHECK: `BUSY`=1; each cycle compare pick[index] with all four latched W in parallel; hit -> counter++; index 0..3; after index 3 go REPORT.
- REPORT: `MATCHES`,`WIN` driven from counter, held stable; `DONE` high only first REPORT cycle. Stays until `CLR`.
- ERROR: `ERR`=1, `MATCHES`=0, `WIN`=0; stays until `CLR`.
- `CLR` from any state -> IDLE next cycle; `CLR` wins over simultaneous `NUM_VLD`. `NUM_VLD` outside ENTRY ignored.
- Changes on W1..W4 after latching have no effect on current ticket.
- Counter 3 bits, saturation impossible (max 4).

## Timing
- Reset values: state IDLE, `READY`=0, `BUSY`=0, `DONE`=0, `MATCHES`=0, `WIN`=0, `ERR`=0, pick regs/count/counter 0.
- All outputs registered or decoded from state; no combinational path from inputs to outputs.
- IDLE->ENTRY: `READY` high one cycle after `SYSRDY` sampled 1.
- 4th pick accepted at edge t: `BUSY` high cycles t+1..t+4, `DONE` pulse and `MATCHES`/`WIN` valid at t+5.
- Illegal pick or `SYSRDY` drop sampled at edge t: `ERR` high from t+1.
- `RST` mid-operation: immediate return to reset values regardless of clock.

## Structure
- Package `lottery_pkg`: state enum, `NUM_PICKS`=4, 5-bit number type, default `MAX_NUM`/`MIN_WIN`.
- Sub-module `pick_compare`: combinational, one 5-bit pick vs four 5-bit values -> hit bit; used in CHECK and reused for duplicate check in ENTRY (against stored picks, masked by count).

## Test plan
- W=5,12,19,27, SYSRDY=1, picks 5,12,19,27 -> DONE at t+5, MATCHES=4, WIN=1.
- Same W, picks 1,12,30,27 -> MATCHES=2, WIN=0; REPORT held until CLR, then IDLE.
- Picks 7,7 -> ERR=1 one cycle after second 7, READY=0; CLR -> IDLE, ERR=0.
- Pick 0 as first entry -> ERR; separately MAX_NUM=20, pick 25 -> ERR.
- SYSRDY drops after 2 picks -> ERR next cycle; W changed to 1,2,3,4 during CHECK of ticket 5,12,19,27 -> still MATCHES=4.
- RST asserted mid-CHECK -> all outputs 0 immediately; CLR and NUM_VLD same cycle in ENTRY -> IDLE, pick not stored.
